// File: rtl/add_accum.sv
// Accumulation stage around the 4-bit adder: sums COUNT operands per batch
// and reports the sum mod 16 plus the number of carry-outs.
module add_accum #(
    parameter int COUNT = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_data,
    output logic [3:0]    add_num1,
    output logic [3:0]    add_num2,
    input  logic [3:0]    add_out,
    input  logic          add_cout,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [3:0]    res_sum,
    output logic [CW-1:0] res_carries
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(COUNT);

    logic [1:0]    state;
    logic [3:0]    acc;
    logic [CW-1:0] carries;
    logic [7:0]    cnt;

    logic          st_done;
    logic          accept;
    logic          last;
    logic          sat;
    logic [CW-1:0] car_nxt;
    logic [7:0]    cnt_nxt;

    assign st_done   = (state == DONE);
    assign in_ready  = !st_done;
    assign accept    = in_valid && in_ready;
    assign cnt_nxt   = cnt + 8'd1;
    assign last      = (cnt_nxt == CNT_LAST);
    assign sat       = &carries;

    // Saturate rather than wrap so an overflowing batch never under-reports.
    assign car_nxt   = (add_cout && !sat) ? carries + CW'(1) : carries;

    assign add_num1    = acc;
    assign add_num2    = in_data;
    assign res_valid   = st_done;
    assign res_sum     = acc;
    assign res_carries = carries;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            carries <= '0;
            cnt     <= '0;
        end else if (clr) begin
            state   <= IDLE;
            acc     <= '0;
            carries <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc     <= add_out;
                        carries <= car_nxt;
                        cnt     <= cnt_nxt;
                        state   <= last ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state   <= IDLE;
                        acc     <= '0;
                        carries <= '0;
                        cnt     <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    acc     <= '0;
                    carries <= '0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/add_accum.md
# add_accum

Sequential accumulation stage wrapped around the 4-bit combinational adder `add`. It accepts a stream of 4-bit operands over a valid/ready handshake and drives the adder with the running accumulator and the incoming operand. It captures the adder's `out`/`cout` each accepted beat and presents the batch result (sum mod 16 plus number of carry-outs) on a second valid/ready handshake after `COUNT` operands.

## Interface
- `COUNT`, 4: operands per batch; legal range 1..255.
- `CW`, 8: width of the carry counter; the counter saturates at 2^CW-1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear; highest priority after reset.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  operand ready.
- `in_data`  in  4  operand.
- `add_num1`  out  4  to adder `num1`; equals the accumulator register.
- `add_num2`  out  4  to adder `num2`; equals `in_data`, combinational passthrough.
- `add_out`  in  4  adder sum.
- `add_cout`  in  1  adder carry-out.
- `res_valid`  out  1  batch result valid.
- `res_ready`  in  1  result consumer ready.
- `res_sum`  out  4  accumulator value (batch sum mod 16).
- `res_carries`  out  CW  number of carry-outs in the batch, saturating.

## Operation
- States:
  - IDLE: no operand accepted yet.
  - ACCUM: batch in progress.
  - DONE: result held for the consumer.
- Registers: `acc[3:0]`, `carries[CW-1:0]`, `cnt[7:0]`.
- An operand is accepted when `in_valid && in_ready`.
- `in_ready = (state != DONE)`. It depends on registered state only, never on `in_valid`.
- On each accepted operand:
  - `acc <= add_out`.
  - `carries <= carries + add_cout`, saturating at 2^CW-1 with no wrap.
  - `cnt <= cnt + 1`.
- Transitions:
  - IDLE goes to ACCUM on an accept, unless that accept is operand number `COUNT`, in which case it goes to DONE. With `COUNT`=1, IDLE goes directly to DONE.
  - ACCUM goes to DONE on the accept that makes the accepted count equal `COUNT`.
  - DONE goes to IDLE on `res_valid && res_ready`. On that edge `acc`, `carries` and `cnt` are zeroed.
- `res_valid = (state == DONE)`. `res_sum = acc`. `res_carries = carries`.
  - `res_sum` and `res_carries` are meaningful only while `res_valid` is high, and are stable for the whole DONE interval.
- Arithmetic is 4-bit modular. The adder's `cout` is the only overflow indication, and each accept contributes at most 1 to `carries`.
- Idle cycles (`in_valid` low) in IDLE or ACCUM change nothing.
- `clr` high at an edge, in any state:
  - next state is IDLE; `acc`, `carries` and `cnt` are zeroed.
  - any operand presented in that cycle is discarded.
  - a pending result is dropped even if `res_ready` is high.
- `rst_n` low, asynchronously, mid-batch or in DONE: same effect as `clr`.

## Timing
- Reset values:
  - state IDLE; `acc`=0, `carries`=0, `cnt`=0.
  - `in_ready`=1, `res_valid`=0, `res_sum`=0, `res_carries`=0.
  - `add_num1`=0; `add_num2` follows `in_data`.
- Operand path: `add_out` must settle in the same cycle as `in_data`; there are no pipeline registers before the adder.
- Accept throughput: one operand per cycle in IDLE/ACCUM.
- Result latency: `res_valid` rises in the cycle after the `COUNT`-th accept.
- Backpressure: while `res_ready` is low in DONE, `res_valid` stays high, outputs hold, and `in_ready` stays 0.
- After the result handshake edge: `in_ready`=1 and `res_valid`=0 in the next cycle. The first operand of the next batch can be accepted in that cycle, so the minimum bubble between batches is one cycle.
- Simultaneous `clr` and the `COUNT`-th accept: `clr` wins and the state is IDLE, all zero.
- Simultaneous `clr` and a result handshake: outcome is IDLE, all zero; the result counts as dropped.

## Test plan
- Reset, then `COUNT`=4, operands 1,1,1,1 with `res_ready`=1:
  - `res_valid` pulses for 1 cycle with `res_sum`=4, `res_carries`=0.
  - `add_num1` sequence is 0,1,2,3.
- Operands 15,1,10,10:
  - acc goes 15, 0, 10, 4.
  - result `res_sum`=4, `res_carries`=2.
- Backpressure: hold `res_ready`=0 for 5 cycles after `res_valid` rises with `in_valid`=1 and `in_data`=7.
  - `in_ready`=0 throughout; result stable; no operand consumed.
  - the next batch starts only after the handshake.
- `in_valid` gaps: operands 5, gap, 3, gap, gap, 0, 8.
  - result `res_sum`=0, `res_carries`=1.
  - `res_valid` one cycle after the 4th accept.
- `clr` after 2 accepts (5,3), then operands 7,8,0,0:
  - result `res_sum`=15, `res_carries`=0, with no contribution from the cleared operands.
- Saturation, `COUNT`=8, `CW`=2, eight operands of 15:
  - `res_sum`=8; 7 carries saturate so `res_carries`=3.
  - Repeat the run with `rst_n` pulsed low mid-batch: outputs return to reset values immediately, and a new batch after reset behaves as from power-up.
